// File: rtl/fx3_port_sched_pkg.sv
// fx3_sched_pkg: shared constants for the FX3 port scheduler.
//   - state_e   : scheduler FSM encoding (IDLE..ABORT)
//   - GNT_*     : grant encoding, also equal to the bus direction of that port
//   - *_ADDR_DEF: default FX3 socket addresses
//   - WDOG_W    : watchdog counter width
package fx3_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // Grant value doubles as bus direction: DPO (1) means the FPGA drives the bus.
  localparam logic GNT_DPI = 1'b0;
  localparam logic GNT_DPO = 1'b1;

  localparam logic [1:0] DPI_ADDR_DEF = 2'd0;
  localparam logic [1:0] DPO_ADDR_DEF = 2'd3;

  localparam int WDOG_W = 10;

endpackage

// File: rtl/fx3_port_sched_if.sv
// fx3_port_sched_if: bundle between the scheduler, the two data-port FSMs
// and the FX3 pads.
//   master : scheduler side (drives strt/abort/addr/dir/status)
//   slave  : environment side (drives flags, FIFO status, enable, done)
// Handshake: strt_o is a one-cycle pulse; the started FSM later answers
// with a one-cycle done_i. If done_i does not arrive within the watchdog
// window, a one-cycle abort_o is issued instead. abort_o is meant to be
// OR'd into that FSM's reset.
// dbg_state exposes the scheduler FSM state.
interface fx3_port_sched_if;
  import fx3_sched_pkg::*;

  logic        en_i;
  logic        dpi_flag_i;
  logic        dpi_full_i;
  logic        dpo_flag_i;
  logic        dpo_empty_i;
  logic        dpi_strt_o;
  logic        dpi_done_i;
  logic        dpi_abort_o;
  logic        dpo_strt_o;
  logic        dpo_done_i;
  logic        dpo_abort_o;
  logic [1:0]  fx3_addr_o;
  logic        bus_dir_o;
  logic        busy_o;
  logic        tout_o;
  logic [15:0] tout_cnt_o;
  state_e      dbg_state;

  modport master (
    input  en_i, dpi_flag_i, dpi_full_i, dpo_flag_i, dpo_empty_i,
    input  dpi_done_i, dpo_done_i,
    output dpi_strt_o, dpi_abort_o, dpo_strt_o, dpo_abort_o,
    output fx3_addr_o, bus_dir_o, busy_o, tout_o, tout_cnt_o, dbg_state
  );

  modport slave (
    output en_i, dpi_flag_i, dpi_full_i, dpo_flag_i, dpo_empty_i,
    output dpi_done_i, dpo_done_i,
    input  dpi_strt_o, dpi_abort_o, dpo_strt_o, dpo_abort_o,
    input  fx3_addr_o, bus_dir_o, busy_o, tout_o, tout_cnt_o, dbg_state
  );

endinterface

// File: rtl/fx3_port_sched_wdog.sv
// fx3_sched_wdog: WAIT_DONE watchdog plus saturating timeout counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the watchdog (start of a transaction)
//   en       : count this cycle (waiting for done)
//   inc      : bump the timeout counter (an abort is being issued)
//   expire   : this enabled cycle is the TOUT-th one
//   tout_cnt : number of timeouts so far, saturating at 16'hFFFF
module fx3_sched_wdog
  import fx3_sched_pkg::*;
#(
  parameter int TOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        inc,
  output logic        expire,
  output logic [15:0] tout_cnt
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TOUT - 1);
  localparam logic [WDOG_W-1:0] ONE  = WDOG_W'(1);

  logic [WDOG_W-1:0] cnt;

  // cnt holds the number of enabled cycles already spent, so the TOUT-th
  // enabled cycle sees TOUT-1 and is flagged combinationally.
  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tout_cnt <= '0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + ONE;
      end
      if (inc && (tout_cnt != 16'hFFFF)) begin
        tout_cnt <= tout_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/fx3_port_sched.sv
// fx3_port_sched: arbitrates the FX3 GPIFII slave-FIFO bus between the
// input data-port FSM (DPI, FX3->FPGA) and the output data-port FSM
// (DPO, FPGA->FX3). It drives the socket address and bus direction, holds
// them for a setup window (longer when direction flips), pulses the granted
// FSM's start, waits for its done and aborts it on a watchdog timeout.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : fx3_port_sched_if.master (requests, handshakes, pads)
module fx3_port_sched
  import fx3_sched_pkg::*;
#(
  parameter logic [1:0] DPI_ADDR   = DPI_ADDR_DEF,
  parameter logic [1:0] DPO_ADDR   = DPO_ADDR_DEF,
  parameter int         ADDR_SETUP = 2,
  parameter int         TURN       = 2,
  parameter int         TOUT       = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fx3_port_sched_if.master  bus
);

  localparam int SETUP_W = $clog2(ADDR_SETUP + TURN + 1);
  localparam logic [SETUP_W-1:0] LD_SAME = SETUP_W'(ADDR_SETUP);
  localparam logic [SETUP_W-1:0] LD_TURN = SETUP_W'(ADDR_SETUP + TURN);
  localparam logic [SETUP_W-1:0] ONE     = SETUP_W'(1);

  state_e             state, state_nxt;
  logic               last_gnt, last_gnt_nxt;
  logic [1:0]         addr, addr_nxt;
  logic               dir, dir_nxt;
  logic [SETUP_W-1:0] setup_cnt, setup_cnt_nxt;

  logic dpi_req, dpo_req, pick, done_gnt;
  logic wd_clr, wd_en, wd_expire, tout_inc;

  assign dpi_req = bus.en_i && !bus.dpi_flag_i && !bus.dpi_full_i;
  assign dpo_req = bus.en_i && !bus.dpo_flag_i && !bus.dpo_empty_i;

  // Round-robin on contention; otherwise whichever port asks.
  assign pick = (dpi_req && dpo_req) ? ~last_gnt : dpo_req;

  // last_gnt is also the port owning the current transaction.
  assign done_gnt = (last_gnt == GNT_DPO) ? bus.dpo_done_i : bus.dpi_done_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      last_gnt  <= GNT_DPO;
      addr      <= DPI_ADDR;
      dir       <= 1'b0;
      setup_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      addr      <= addr_nxt;
      dir       <= dir_nxt;
      setup_cnt <= setup_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    addr_nxt      = addr;
    dir_nxt       = dir;
    setup_cnt_nxt = setup_cnt;
    wd_clr        = 1'b0;
    wd_en         = 1'b0;
    tout_inc      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (dpi_req || dpo_req) begin
          last_gnt_nxt  = pick;
          dir_nxt       = pick;
          addr_nxt      = (pick == GNT_DPO) ? DPO_ADDR : DPI_ADDR;
          // The counter covers every SETUP cycle; START follows the last one.
          setup_cnt_nxt = (pick != dir) ? LD_TURN : LD_SAME;
          state_nxt     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt == ONE) begin
          state_nxt = ST_START;
        end else begin
          setup_cnt_nxt = setup_cnt - ONE;
        end
      end
      ST_START: begin
        wd_clr    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // done takes priority over a simultaneous expiry.
        if (done_gnt) begin
          state_nxt = ST_IDLE;
        end else if (wd_expire) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        tout_inc  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  fx3_sched_wdog #(.TOUT(TOUT)) u_wdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (wd_clr),
    .en       (wd_en),
    .inc      (tout_inc),
    .expire   (wd_expire),
    .tout_cnt (bus.tout_cnt_o)
  );

  assign bus.dpi_strt_o  = (state == ST_START) && (last_gnt == GNT_DPI);
  assign bus.dpo_strt_o  = (state == ST_START) && (last_gnt == GNT_DPO);
  assign bus.dpi_abort_o = (state == ST_ABORT) && (last_gnt == GNT_DPI);
  assign bus.dpo_abort_o = (state == ST_ABORT) && (last_gnt == GNT_DPO);
  assign bus.tout_o      = (state == ST_ABORT);
  assign bus.busy_o      = (state != ST_IDLE);
  assign bus.fx3_addr_o  = addr;
  assign bus.bus_dir_o   = dir;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_fx3_port_sched.sv
// tb_fx3_port_sched: directed phases followed by random traffic, checked
// every cycle against a transaction-timeline model of the scheduler.
module tb_fx3_port_sched;
  import fx3_sched_pkg::*;

  localparam int AS    = 2;
  localparam int TURN  = 2;
  localparam int TOUT  = 1023;
  localparam int NEVER = 100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx3_port_sched_if bus_if ();

  fx3_port_sched #(
    .DPI_ADDR   (2'd0),
    .DPO_ADDR   (2'd3),
    .ADDR_SETUP (AS),
    .TURN       (TURN),
    .TOUT       (TOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.master)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- stimulus policy ----------------
  logic p_rand      = 1'b0;
  logic p_rst       = 1'b1;
  logic p_en        = 1'b0;
  logic p_dpi_req   = 1'b0;
  logic p_dpo_req   = 1'b0;
  int   p_delay     = 3;

  // ---------------- reference model (timeline of one transaction) -------
  logic        m_active;
  logic        m_gnt;
  logic        m_last;
  logic        m_dir;
  logic [1:0]  m_addr;
  logic [15:0] m_tout;
  int          m_start;
  int          m_grant;
  int          m_delay;

  task automatic model_reset();
    m_active = 1'b0;
    m_gnt    = GNT_DPO;
    m_last   = GNT_DPO;
    m_dir    = 1'b0;
    m_addr   = 2'd0;
    m_tout   = 16'd0;
    m_start  = 0;
    m_grant  = 0;
    m_delay  = NEVER;
  endtask

  task automatic compare_outputs();
    logic [4:0] got_p, exp_p;
    logic       ab;
    ab    = m_active && (cyc == m_start + TOUT + 1);
    exp_p = {m_active && cyc == m_start && m_gnt == GNT_DPI,
             m_active && cyc == m_start && m_gnt == GNT_DPO,
             ab && m_gnt == GNT_DPI,
             ab && m_gnt == GNT_DPO,
             ab};
    got_p = {bus_if.dpi_strt_o, bus_if.dpo_strt_o, bus_if.dpi_abort_o,
             bus_if.dpo_abort_o, bus_if.tout_o};
    check("pulses",   16'(got_p), 16'(exp_p));
    check("addr",     16'(bus_if.fx3_addr_o), 16'(m_addr));
    check("dir",      16'(bus_if.bus_dir_o), 16'(m_dir));
    check("busy",     16'(bus_if.busy_o), 16'(m_active));
    check("tout_cnt", bus_if.tout_cnt_o, m_tout);
  endtask

  task automatic drive_inputs();
    logic due;
    if (p_rand) begin
      rst                = ($urandom_range(0, 399) == 0);
      bus_if.en_i        = ($urandom_range(0, 7) != 0);
      bus_if.dpi_flag_i  = 1'($urandom_range(0, 1));
      bus_if.dpi_full_i  = ($urandom_range(0, 3) == 0);
      bus_if.dpo_flag_i  = 1'($urandom_range(0, 1));
      bus_if.dpo_empty_i = ($urandom_range(0, 3) == 0);
    end else begin
      rst                = p_rst;
      bus_if.en_i        = p_en;
      bus_if.dpi_flag_i  = !p_dpi_req;
      bus_if.dpi_full_i  = 1'b0;
      bus_if.dpo_flag_i  = !p_dpo_req;
      bus_if.dpo_empty_i = 1'b0;
    end
    due = m_active && (cyc == m_start + m_delay);
    // Random mode also throws done pulses from the port that does not own
    // the bus; those must be ignored.
    bus_if.dpi_done_i = (due && m_gnt == GNT_DPI) ||
                        (p_rand && m_active && m_gnt == GNT_DPO && $urandom_range(0, 3) == 0);
    bus_if.dpo_done_i = (due && m_gnt == GNT_DPO) ||
                        (p_rand && m_active && m_gnt == GNT_DPI && $urandom_range(0, 3) == 0);
  endtask

  task automatic model_update();
    logic dreq, oreq, g, gdone;
    dreq  = bus_if.en_i && !bus_if.dpi_flag_i && !bus_if.dpi_full_i;
    oreq  = bus_if.en_i && !bus_if.dpo_flag_i && !bus_if.dpo_empty_i;
    gdone = (m_gnt == GNT_DPO) ? bus_if.dpo_done_i : bus_if.dpi_done_i;
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      if (cyc > m_start && cyc <= m_start + TOUT && gdone) begin
        m_active = 1'b0;
      end else if (cyc == m_start + TOUT + 1) begin
        m_active = 1'b0;
        if (m_tout != 16'hFFFF) m_tout = m_tout + 16'd1;
      end
    end else if (dreq || oreq) begin
      g        = (dreq && oreq) ? !m_last : oreq;
      m_start  = cyc + 1 + AS + ((g != m_dir) ? TURN : 0);
      m_grant  = cyc;
      m_gnt    = g;
      m_last   = g;
      m_dir    = g;
      m_addr   = g ? 2'd3 : 2'd0;
      m_active = 1'b1;
      if (p_rand) m_delay = ($urandom_range(0, 63) == 0) ? NEVER : int'($urandom_range(1, 8));
      else        m_delay = p_delay;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_outputs();
      drive_inputs();
      model_update();
      cyc++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    model_reset();
    bus_if.en_i        = 1'b0;
    bus_if.dpi_flag_i  = 1'b1;
    bus_if.dpi_full_i  = 1'b0;
    bus_if.dpo_flag_i  = 1'b1;
    bus_if.dpo_empty_i = 1'b1;
    bus_if.dpi_done_i  = 1'b0;
    bus_if.dpo_done_i  = 1'b0;

    // reset state
    run_cycles(3);
    p_rst = 1'b0;

    // DPI only, done 3 cycles after start
    p_en = 1'b1; p_dpi_req = 1'b1; p_dpo_req = 1'b0; p_delay = 3;
    run_cycles(40);

    // both ports contending, done 1 cycle after start
    p_dpo_req = 1'b1; p_delay = 1;
    run_cycles(60);

    // DPO granted, done never arrives
    p_dpi_req = 1'b0; p_delay = NEVER;
    k = 0;
    while (!(m_active && m_gnt == GNT_DPO) && k < 50) begin run_cycles(1); k++; end
    check("reach_dpo_grant", 16'(k < 50), 16'd1);
    p_dpo_req = 1'b0;
    run_cycles(TOUT + 20);
    p_dpo_req = 1'b1; p_delay = 2;
    run_cycles(30);

    // DPI done exactly on the last watchdog cycle
    p_dpo_req = 1'b0; p_dpi_req = 1'b1; p_delay = TOUT;
    k = 0;
    while (!(m_active && m_gnt == GNT_DPI) && k < 50) begin run_cycles(1); k++; end
    check("reach_dpi_grant", 16'(k < 50), 16'd1);
    p_dpi_req = 1'b0;
    run_cycles(TOUT + 20);

    // enable dropped while waiting for done
    p_dpi_req = 1'b1; p_dpo_req = 1'b1; p_delay = 5;
    k = 0;
    while (!(m_active && cyc == m_start + 2) && k < 50) begin run_cycles(1); k++; end
    check("reach_wait", 16'(k < 50), 16'd1);
    p_en = 1'b0;
    run_cycles(30);

    // reset pulsed during SETUP
    p_en = 1'b1;
    k = 0;
    while (!(m_active && cyc > m_grant && cyc < m_start) && k < 50) begin run_cycles(1); k++; end
    check("reach_setup", 16'(k < 50), 16'd1);
    p_rst = 1'b1;
    run_cycles(1);
    p_rst = 1'b0;
    run_cycles(40);

    // random traffic
    p_rand = 1'b1;
    run_cycles(3000);
    p_rand = 1'b0; p_rst = 1'b0; p_en = 1'b0;
    run_cycles(TOUT + 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
